// File: rtl/data_pack.sv
// Packs IN_W-bit samples LSB-first into OUT_W-bit words, keeping packet framing.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module data_pack #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready_out,
   input  logic             valid_in,
   input  logic [IN_W-1:0]  data_in,
   input  logic             sop_in,
   input  logic             eop_in,
   output logic             valid_out,
   output logic [OUT_W-1:0] data_out,
   output logic             sop_out,
   output logic             eop_out,
   input  logic             ready_in
);

   localparam int CNT_W = $clog2(OUT_W + IN_W);
   localparam int ACC_W = OUT_W + IN_W;

   typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

   state_t             state, state_nx;
   logic [ACC_W-1:0]   acc, acc_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               sop_pending, sop_pending_nx;

   logic               out_free;
   logic               accept;
   logic               load;
   logic [OUT_W-1:0]   load_data;
   logic               load_sop;
   logic               load_eop;

   logic [ACC_W-1:0]   base_acc;
   logic [CNT_W-1:0]   base_cnt;
   logic               base_sop;
   logic [ACC_W-1:0]   nacc;
   logic [CNT_W-1:0]   ncnt;

   assign out_free  = !valid_out || ready_in;
   assign ready_out = out_free && (state != FLUSH);
   assign accept    = valid_in && ready_out;

   // A sample carrying sop_in always starts from an empty accumulator,
   // which also drops any partial packet still being collected.
   assign base_acc = sop_in ? '0 : acc;
   assign base_cnt = sop_in ? '0 : cnt;
   assign base_sop = sop_in || sop_pending;
   assign nacc     = base_acc | (ACC_W'(data_in) << base_cnt);
   assign ncnt     = base_cnt + CNT_W'(IN_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         sop_pending <= 1'b0;
      end else begin
         state       <= state_nx;
         acc         <= acc_nx;
         cnt         <= cnt_nx;
         sop_pending <= sop_pending_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      acc_nx         = acc;
      cnt_nx         = cnt;
      sop_pending_nx = sop_pending;
      load           = 1'b0;
      load_data      = nacc[OUT_W-1:0];
      load_sop       = 1'b0;
      load_eop       = 1'b0;
      case (state)
         IDLE, ACC: begin
            // In IDLE only a sop sample opens a packet; anything else is dropped.
            if (accept && (state == ACC || sop_in)) begin
               load_sop = base_sop;
               if (eop_in) begin
                  load = 1'b1;
                  if (ncnt > CNT_W'(OUT_W)) begin
                     acc_nx         = nacc >> OUT_W;
                     cnt_nx         = ncnt - CNT_W'(OUT_W);
                     sop_pending_nx = 1'b0;
                     state_nx       = FLUSH;
                  end else begin
                     load_eop       = 1'b1;
                     acc_nx         = '0;
                     cnt_nx         = '0;
                     sop_pending_nx = 1'b0;
                     state_nx       = IDLE;
                  end
               end else if (ncnt >= CNT_W'(OUT_W)) begin
                  load           = 1'b1;
                  acc_nx         = nacc >> OUT_W;
                  cnt_nx         = ncnt - CNT_W'(OUT_W);
                  sop_pending_nx = 1'b0;
                  state_nx       = ACC;
               end else begin
                  acc_nx         = nacc;
                  cnt_nx         = ncnt;
                  sop_pending_nx = base_sop;
                  state_nx       = ACC;
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               load           = 1'b1;
               load_data      = acc[OUT_W-1:0];
               load_eop       = 1'b1;
               acc_nx         = '0;
               cnt_nx         = '0;
               sop_pending_nx = 1'b0;
               state_nx       = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Single-stage output register; data_out keeps its last value once drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
      end else if (load) begin
         valid_out <= 1'b1;
         data_out  <= load_data;
         sop_out   <= load_sop;
         eop_out   <= load_eop;
      end else if (ready_in) begin
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
      end
   end

endmodule

// File: doc/data_pack.md
Name: data_pack

Overview:
- Packs a stream of 7-bit samples, LSB-first, into 32-bit words.
- Sits directly upstream of the 32-to-7 unpacker and drives its valid/ready/sop/eop input interface.
- Preserves packet framing. The last word of a packet is zero-padded in its unused MSBs.
- Provides valid/ready backpressure on both sides.

Parameters:
IN_W, 7, input sample width in bits; must satisfy 1 <= IN_W < OUT_W
OUT_W, 32, output word width in bits
CNT_W, $clog2(OUT_W+IN_W), width of the accumulated-bit counter (derived, not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
ready_out  output  1  block can accept a sample this cycle
valid_in  input  1  sample present; transfer when valid_in & ready_out
data_in  input  IN_W  sample, LSB-aligned
sop_in  input  1  first sample of a packet
eop_in  input  1  last sample of a packet
valid_out  output  1  output word present
data_out  output  OUT_W  packed word; first sample occupies bits [IN_W-1:0]
sop_out  output  1  first word of a packet
eop_out  output  1  last word of a packet
ready_in  input  1  downstream accepts; transfer when valid_out & ready_in

Behaviour:
- Reset values: valid_out=0, data_out=0, sop_out=0, eop_out=0, accumulator=0, count=0, sop_pending=0, state=IDLE. ready_out=1 in the cycle after reset deasserts.
- Output register is a single stage.
- out_free = !valid_out | ready_in.
- ready_out = out_free & (state != FLUSH).
- A downstream transfer with no new load clears valid_out, sop_out and eop_out. data_out holds its value.
- While valid_out=1 & ready_in=0: data_out, sop_out and eop_out are held stable.
- Accept (valid_in & ready_out) computes:
  - nacc = acc | (data_in << cnt)
  - ncnt = cnt + IN_W
- States:
  - IDLE: samples without sop_in are accepted and discarded. An accepted sample with sop_in clears acc/cnt, sets sop_pending, processes the sample as below and goes to ACC.
  - ACC, accept without eop_in:
    - If ncnt >= OUT_W: load the output register with nacc[OUT_W-1:0], sop_out=sop_pending, eop_out=0. Then acc = nacc >> OUT_W, cnt = ncnt - OUT_W, clear sop_pending.
    - Otherwise: acc = nacc, cnt = ncnt, no output.
  - ACC, accept with eop_in:
    - ncnt < OUT_W: emit nacc with upper bits zero, eop_out=1. Clear acc/cnt and go to IDLE.
    - ncnt == OUT_W: emit nacc with eop_out=1. Clear state and go to IDLE.
    - ncnt > OUT_W: emit nacc[OUT_W-1:0] with eop_out=0, keep the residual and go to FLUSH.
  - FLUSH: ready_out=0. When out_free, emit the zero-padded residual with eop_out=1 and sop_out=0. Clear acc/cnt and go to IDLE.
- sop_in accepted while in ACC: the partial packet is discarded and no eop is emitted. The new packet starts cleanly with this sample.
- sop_in & eop_in on the same sample: a one-word packet with sop_out=eop_out=1.
- Latency: a completed word appears on valid_out the cycle after the accept of the sample that completes it.
- Throughput: with ready_in held at 1, one sample is accepted per cycle. The only input bubble is the single FLUSH cycle. Back-to-back packets produce no output gap beyond that bubble.
- rst mid-packet: all state is discarded, including any held output word, and no partial word is emitted.
- Packets of 32 samples (224 bits) yield exactly 7 words with no flush.

Test Plan:
1. Assert rst for 2 cycles with random inputs -> valid_out/sop_out/eop_out=0, data_out=0; ready_out=1 after release.
2. Packet of 32 samples, value i for i=0..31, ready_in=1, contiguous -> exactly 7 words with no gaps:
   - word0=0x40608080, with sop_out on word0 only.
   - eop_out on word6 only.
   - ready_out constantly 1.
3. Packet of 5 samples of 7'h7F (35 bits) -> word0=0xFFFFFFFF with sop=1, eop=0. Then word1=0x00000007 with eop=1. ready_out=0 for exactly 1 cycle.
4. Single sample 7'h2A with sop_in=eop_in=1 -> one word 0x0000002A with sop_out=eop_out=1, one cycle after accept.
5. ready_in=0 for 3 cycles while word0 of the scenario 2 packet is presented -> data_out/sop_out held stable, ready_out=0 for those cycles, no sample lost. The full 7-word sequence matches scenario 2.
6. Framing errors:
   - 3 samples without sop_in -> no output.
   - Then sop_in at sample 2 of a packet interrupting 2 prior samples -> output reflects only the new packet; the first word carries sop_out and contains the new samples at bit 0.
